// File: rtl/pmod_in_capture.sv
// ---------------------------------------------------------------------------
// pmod_in_capture
//
// Input-side capture for PMOD pins that come back from the IOBUF O outputs.
// Each pin is synchronised and debounced, and its edges are detected. Edges
// set sticky status bits and drive a level interrupt. They are also queued
// as events in a small FIFO that is drained over a valid/ready stream.
//
// Optional build macro:
//   PMOD_IN_TIMESTAMP_EN - adds a 32-bit free-running cycle counter.
//                          Each queued event carries the counter value taken
//                          in its edge-detect cycle, presented on ev_time.
//
// Ports:
//   aclk         clock for all logic
//   aresetn      synchronous active-low reset
//   pin_in       raw (asynchronous) pin levels
//   pin_tri      1 = pin is an input and is sampled, 0 = pin ignored
//   rise_en      per-pin rising-edge event enable
//   fall_en      per-pin falling-edge event enable
//   clr_valid    one-cycle status clear strobe
//   clr_mask     pins whose rise/fall status is cleared on clr_valid
//   clr_drop     also clear ev_drop on clr_valid
//   level_out    debounced pin levels
//   rise_status  sticky rising-edge flags
//   fall_status  sticky falling-edge flags
//   irq          registered OR of all status bits
//   ev_valid     event FIFO head is valid
//   ev_ready     consumer accepts the head
//   ev_data      {edge (1 = rise), pin index}
//   ev_drop      sticky: at least one event was lost
//   ev_time      (PMOD_IN_TIMESTAMP_EN only) timestamp of the head event
// ---------------------------------------------------------------------------
module pmod_in_capture #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [WIDTH-1:0]        pin_in,
  input  logic [WIDTH-1:0]        pin_tri,
  input  logic [WIDTH-1:0]        rise_en,
  input  logic [WIDTH-1:0]        fall_en,
  input  logic                    clr_valid,
  input  logic [WIDTH-1:0]        clr_mask,
  input  logic                    clr_drop,
  output logic [WIDTH-1:0]        level_out,
  output logic [WIDTH-1:0]        rise_status,
  output logic [WIDTH-1:0]        fall_status,
  output logic                    irq,
  output logic                    ev_valid,
  input  logic                    ev_ready,
  output logic [$clog2(WIDTH):0]  ev_data,
  output logic                    ev_drop
`ifdef PMOD_IN_TIMESTAMP_EN
  ,
  output logic [31:0]             ev_time
`endif
);

  localparam int IW = $clog2(WIDTH);
  localparam int EW = IW + 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);
  localparam logic [PW:0]   COUNT_FULL = (PW + 1)'(FIFO_DEPTH);

  // -------------------------------------------------------------------------
  // Two-flop synchroniser
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] sync;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= pin_in;
      sync <= meta;
    end
  end

  // -------------------------------------------------------------------------
  // Debounce: a new level is accepted once sync has differed from level_out
  // for DEBOUNCE_CYCLES consecutive cycles (the counter holds 0..N-1 while
  // the difference persists). A masked (driven) pin freezes with its counter
  // at 0, so debounce restarts cleanly from the held level when unmasked.
  // DEBOUNCE_CYCLES = 0 accepts the synchronised level every cycle.
  // -------------------------------------------------------------------------
  logic [CW-1:0] db_cnt [WIDTH];

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      level_out <= '0;
      for (int i = 0; i < WIDTH; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!pin_tri[i] || (sync[i] == level_out[i])) begin
          db_cnt[i] <= '0;
        end else if ((DEBOUNCE_CYCLES == 0) || (db_cnt[i] == CNT_LAST)) begin
          level_out[i] <= sync[i];
          db_cnt[i]    <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Edge detect. It runs in the cycle after a level_out update, against a
  // one-cycle-delayed copy of level_out.
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] level_q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edges;

  always_ff @(posedge aclk) begin
    if (!aresetn) level_q <= '0;
    else          level_q <= level_out;
  end

  assign rise  =  level_out & ~level_q & rise_en;
  assign fall  = ~level_out &  level_q & fall_en;
  assign edges = rise | fall;

  // -------------------------------------------------------------------------
  // Sticky status and interrupt. A new edge wins over a clear of the same bit.
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] clr_bits;

  assign clr_bits = clr_valid ? clr_mask : '0;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rise_status <= '0;
      fall_status <= '0;
      irq         <= 1'b0;
    end else begin
      rise_status <= (rise_status & ~clr_bits) | rise;
      fall_status <= (fall_status & ~clr_bits) | fall;
      irq         <= |(rise_status | fall_status);
    end
  end

  // -------------------------------------------------------------------------
  // Event selection: the lowest-index pin with an edge is pushed. Any other
  // same-cycle edges are counted as drops.
  // -------------------------------------------------------------------------
  logic [EW-1:0] push_entry;
  logic          push;
  logic          multi_edge;

  always_comb begin
    push_entry = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (edges[i]) begin
        push_entry     = EW'(i);
        push_entry[IW] = rise[i];
      end
    end
  end

  assign push       = |edges;
  assign multi_edge = |(edges & (edges - 1'b1));

  // -------------------------------------------------------------------------
  // Event FIFO
  //
  // Stream handshake: an event transfers on every aclk edge where ev_valid
  // and ev_ready are both 1. ev_valid never depends on ev_ready. While
  // ev_valid is high and ev_ready is low, the head (ev_data/ev_time) holds.
  // A push into a full FIFO still succeeds when a pop happens in the same
  // cycle.
  // -------------------------------------------------------------------------
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          full;
  logic          pop;
  logic          do_push;
  logic          drop_new;

  assign full     = (count == COUNT_FULL);
  assign ev_valid = (count != '0);
  assign pop      = ev_valid && ev_ready;
  assign do_push  = push && (!full || pop);
  assign drop_new = multi_edge || (push && full && !pop);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the outputs are gated by ev_valid instead.
  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  assign ev_data = ev_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ev_drop <= 1'b0;
    end else if (drop_new) begin
      ev_drop <= 1'b1;
    end else if (clr_valid && clr_drop) begin
      ev_drop <= 1'b0;
    end
  end

`ifdef PMOD_IN_TIMESTAMP_EN
  // -------------------------------------------------------------------------
  // Timestamp: free-running counter that wraps naturally at 32 bits. It is
  // captured alongside the entry in the edge-detect cycle.
  // -------------------------------------------------------------------------
  logic [31:0] ts_cnt;
  logic [31:0] ts_mem [FIFO_DEPTH];

  always_ff @(posedge aclk) begin
    if (!aresetn) ts_cnt <= '0;
    else          ts_cnt <= ts_cnt + 32'd1;
  end

  always_ff @(posedge aclk) begin
    if (do_push) ts_mem[wr_ptr] <= ts_cnt;
  end

  assign ev_time = ev_valid ? ts_mem[rd_ptr] : '0;
`endif

endmodule

// File: tb/tb_pmod_in_capture.sv
// ---------------------------------------------------------------------------
// tb_pmod_in_capture
//
// Directed bench for pmod_in_capture with WIDTH=8, DEBOUNCE_CYCLES=4 and
// FIFO_DEPTH=4. Inputs are driven and outputs sampled on the falling clock
// edge. Expected FIFO entries are queued by hand in exp_q and compared as
// the FIFO drains.
// ---------------------------------------------------------------------------
module tb_pmod_in_capture;

  localparam int WIDTH = 8;

  // clock / reset
  logic clk = 1'b0;
  logic aresetn;
  always #5 clk = ~clk;

  logic [WIDTH-1:0] pin_in, pin_tri, rise_en, fall_en, clr_mask;
  logic             clr_valid, clr_drop, ev_ready;
  logic [WIDTH-1:0] level_out, rise_status, fall_status;
  logic             irq, ev_valid, ev_drop;
  logic [3:0]       ev_data;
`ifdef PMOD_IN_TIMESTAMP_EN
  logic [31:0]      ev_time;
`endif

  pmod_in_capture #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (4),
    .FIFO_DEPTH      (4)
  ) dut (
    .aclk        (clk),
    .aresetn     (aresetn),
    .pin_in      (pin_in),
    .pin_tri     (pin_tri),
    .rise_en     (rise_en),
    .fall_en     (fall_en),
    .clr_valid   (clr_valid),
    .clr_mask    (clr_mask),
    .clr_drop    (clr_drop),
    .level_out   (level_out),
    .rise_status (rise_status),
    .fall_status (fall_status),
    .irq         (irq),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_data     (ev_data),
    .ev_drop     (ev_drop)
`ifdef PMOD_IN_TIMESTAMP_EN
    ,
    .ev_time     (ev_time)
`endif
  );

  // scoreboard
  logic [3:0] exp_q[$];
  int         total = 0;
  int         bad   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp,
               $time);
    end
  endtask

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear(input logic [WIDTH-1:0] mask, input logic drop);
    clr_valid = 1'b1;
    clr_mask  = mask;
    clr_drop  = drop;
    step(1);
    clr_valid = 1'b0;
    clr_mask  = '0;
    clr_drop  = 1'b0;
  endtask

  // Move pins to a new level with events disabled, then wipe status/drop.
  task automatic quiet(input logic [WIDTH-1:0] lvl);
    rise_en = '0;
    fall_en = '0;
    pin_in  = lvl;
    step(10);
    clear('1, 1'b1);
    step(2);
  endtask

  // Pop everything the DUT holds, matching against exp_q in order.
  task automatic drain();
    int n_exp = exp_q.size();
    int pops  = 0;
    ev_ready = 1'b1;
    while (ev_valid && pops < 16) begin
      pops++;
      if (exp_q.size() != 0) check("ev_data", ev_data, exp_q.pop_front());
      step(1);
    end
    ev_ready = 1'b0;
    check("ev_count", pops, n_exp);
    check("ev_valid_end", ev_valid, 0);
    exp_q.delete();
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  int pins[5] = '{0, 1, 3, 4, 6};

  initial begin
    aresetn   = 1'b0;
    pin_in    = '0;
    pin_tri   = 8'hFF;
    rise_en   = '0;
    fall_en   = '0;
    clr_valid = 1'b0;
    clr_mask  = '0;
    clr_drop  = 1'b0;
    ev_ready  = 1'b0;
    @(negedge clk);

    // 1. reset while pins toggle
    for (int k = 0; k < 3; k++) begin
      pin_in = ~pin_in;
      step(1);
    end
    check("rst_level", level_out, 0);
    check("rst_rise", rise_status, 0);
    check("rst_fall", fall_status, 0);
    check("rst_irq", irq, 0);
    check("rst_valid", ev_valid, 0);
    check("rst_data", ev_data, 0);
    check("rst_drop", ev_drop, 0);
    aresetn = 1'b1;
    pin_in  = '0;
    step(2);
    check("rel_level", level_out, 0);
    check("rel_valid", ev_valid, 0);
    check("rel_irq", irq, 0);

    // 2. glitch filtering, then a real rise on pin 0
    rise_en = 8'h01;
    pin_in  = 8'h01;
    step(3);
    pin_in  = 8'h00;
    step(10);
    check("glitch_level", level_out, 0);
    check("glitch_valid", ev_valid, 0);
    pin_in = 8'h01;
    step(5);
    check("lat_before", level_out, 8'h00);
    step(1);
    check("lat_level", level_out, 8'h01);
    step(1);
    check("p0_rise", rise_status, 8'h01);
    check("p0_valid", ev_valid, 1);
    check("p0_irq_early", irq, 0);
    exp_q.push_back(4'b1000);
    step(1);
    check("p0_irq", irq, 1);
    drain();

    // 3. two pins in the same cycle: lowest index pushed, the other dropped
    clear('1, 1'b1);
    rise_en = 8'hFF;
    pin_in  = 8'h25;
    step(7);
    check("dual_rise", rise_status, 8'h24);
    check("dual_drop", ev_drop, 1);
    check("dual_fall", fall_status, 0);
    exp_q.push_back(4'b1010);
    drain();

    // 4. overflow: five single edges into a four-entry FIFO
    quiet(8'h00);
    check("ovf_pre_drop", ev_drop, 0);
    rise_en = 8'hFF;
    for (int k = 0; k < 5; k++) begin
      pin_in[pins[k]] = 1'b1;
      step(8);
      if (k < 4) exp_q.push_back({1'b1, 3'(pins[k])});
      if (k == 3) check("full_no_drop", ev_drop, 0);
    end
    check("ovf_drop", ev_drop, 1);
    check("ovf_rise", rise_status, 8'h5B);
    check("ovf_valid", ev_valid, 1);
    step(2);
    check("ovf_hold", ev_data, exp_q[0]);
    drain();

    // 5. a set wins over a clear in the same cycle; a plain clear drops irq
    quiet(8'h00);
    rise_en = 8'h01;
    pin_in  = 8'h01;
    step(6);
    clear(8'h01, 1'b0);
    check("set_wins", rise_status, 8'h01);
    check("set_irq_early", irq, 0);
    exp_q.push_back(4'b1000);
    step(1);
    check("set_irq", irq, 1);
    step(1);
    clear(8'h01, 1'b0);
    check("clr_rise", rise_status, 0);
    check("clr_irq_lag", irq, 1);
    step(1);
    check("clr_irq", irq, 0);
    drain();

    // 6. a masked pin ignores activity, then resumes debouncing
    quiet(8'h00);
    rise_en = 8'hFF;
    fall_en = 8'hFF;
    pin_tri = 8'hF7;
    for (int k = 0; k < 4; k++) begin
      pin_in[3] = ~pin_in[3];
      step(50);
    end
    check("tri_level", level_out, 0);
    check("tri_rise", rise_status, 0);
    check("tri_fall", fall_status, 0);
    check("tri_valid", ev_valid, 0);
    pin_in  = 8'h08;
    pin_tri = 8'hFF;
    step(5);
    check("tri_lat_before", level_out, 0);
    step(1);
    check("tri_lat_level", level_out, 8'h08);
    step(1);
    check("tri_rise_after", rise_status, 8'h08);
    exp_q.push_back(4'b1011);
    drain();

    // 7. fall event, then reset mid-operation discards the FIFO
    pin_in = 8'h00;
    step(7);
    check("fall_status", fall_status, 8'h08);
    check("fall_valid", ev_valid, 1);
    check("fall_data", ev_data, 4'b0011);
    aresetn = 1'b0;
    step(1);
    check("mid_rst_valid", ev_valid, 0);
    check("mid_rst_data", ev_data, 0);
    check("mid_rst_fall", fall_status, 0);
    check("mid_rst_rise", rise_status, 0);
    check("mid_rst_irq", irq, 0);
    aresetn = 1'b1;
    exp_q.delete();
    step(2);
    check("post_rst_valid", ev_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
